// File: rtl/outport_uart_tx.sv
// Captures changes on the CPU output port into a small FIFO and
// serialises each word as four 8N1 UART frames, LSB byte first.
module outport_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      Output_Data,
    input  logic             Run,
    output logic             Tx,
    output logic             Busy,
    output logic             Overflow,
    output logic [CNT_W-1:0] Fifo_Count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       last_data;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic [31:0]       tx_word;
    logic [31:0]       word_next;
    logic [1:0]        byte_idx;
    logic [1:0]        byte_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic              baud_done;
    logic              tx_next;
    logic              push_req;
    logic              push;
    logic              pop;

    assign push_req  = Run && (Output_Data != last_data);
    assign pop       = (state == IDLE) && (Fifo_Count != '0);
    // A full FIFO still accepts a word when the head leaves on the same edge
    assign push      = push_req && ((Fifo_Count < DEPTH_C) || pop);
    assign baud_done = (baud_cnt == BAUD_MAX);

    always_comb begin
        count_next = Fifo_Count;
        unique case ({push, pop})
            2'b10:   count_next = Fifo_Count + 1'b1;
            2'b01:   count_next = Fifo_Count - 1'b1;
            default: count_next = Fifo_Count;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Fifo_Count <= '0;
            Overflow   <= 1'b0;
        end else begin
            if (push_req) begin
                last_data <= Output_Data;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && !push) begin
                Overflow <= 1'b1;
            end
            Fifo_Count <= count_next;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= Output_Data;
        end
    end

    always_comb begin
        state_next = state;
        word_next  = tx_word;
        byte_next  = byte_idx;
        bit_next   = bit_idx;
        baud_next  = baud_cnt;
        tx_next    = 1'b1;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    word_next  = mem[rd_ptr];
                    byte_next  = 2'd0;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                tx_next = tx_word[{byte_idx, bit_idx}];
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (byte_idx == 2'd3) begin
                        state_next = IDLE;
                    end else begin
                        byte_next  = byte_idx + 1'b1;
                        state_next = START;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
        endcase
    end

    // Tx is a flop so the line stays glitch-free; it trails the state by one cycle
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            tx_word  <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            Tx       <= 1'b1;
            Busy     <= 1'b0;
        end else begin
            state    <= state_next;
            tx_word  <= word_next;
            byte_idx <= byte_next;
            bit_idx  <= bit_next;
            baud_cnt <= baud_next;
            Tx       <= tx_next;
            Busy     <= (state_next != IDLE) || (count_next != '0);
        end
    end

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx with a free-running 8N1 word receiver.
module tb_outport_uart_tx;

    localparam int CLKS = 4;

    logic        Clock;
    logic        Reset;
    logic [31:0] Output_Data;
    logic        Run;
    logic        Tx;
    logic        Busy;
    logic        Overflow;
    logic [2:0]  Fifo_Count;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int frame_err = 0;
    int gap;

    logic [31:0] rx_q [$];
    int          rx_t [$];
    logic [31:0] v3 [6];
    logic [31:0] v4 [5];

    outport_uart_tx #(
        .CLKS_PER_BIT(CLKS),
        .FIFO_DEPTH  (4),
        .CNT_W       (3)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Output_Data(Output_Data),
        .Run        (Run),
        .Tx         (Tx),
        .Busy       (Busy),
        .Overflow   (Overflow),
        .Fifo_Count (Fifo_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(negedge Clock);
            t++;
        end
        chk(tag, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        logic [31:0] obs;
        obs = 'x;
        if (rx_q.size() > 0) begin
            obs = rx_q.pop_front();
            void'(rx_t.pop_front());
        end
        chk(tag, obs, exp);
    endtask

    // Receiver: whole word as 40 contiguous bit cells, sampled mid-cell
    initial begin : rx_mon
        logic [31:0] w;
        logic        bad;
        logic        abort;
        int          t0;
        forever begin
            @(negedge Clock);
            if (Reset === 1'b1 && Tx === 1'b0) begin
                t0    = cyc;
                w     = '0;
                bad   = 1'b0;
                abort = 1'b0;
                for (int k = 0; k < 40 && !abort; k++) begin
                    for (int s = 0; s < CLKS; s++) begin
                        @(negedge Clock);
                        if (Reset !== 1'b1) abort = 1'b1;
                        if (s == 0) begin
                            if (k % 10 == 0) begin
                                if (Tx !== 1'b0) bad = 1'b1;
                            end else if (k % 10 == 9) begin
                                if (Tx !== 1'b1) bad = 1'b1;
                            end else begin
                                w[(k / 10) * 8 + (k % 10) - 1] = Tx;
                            end
                        end
                    end
                end
                if (!abort) begin
                    rx_q.push_back(w);
                    rx_t.push_back(t0);
                    if (bad) frame_err++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v3 = '{32'h11111111, 32'h22222222, 32'h33333333,
               32'h44444444, 32'h55555555, 32'h66666666};
        v4 = '{32'h01010101, 32'h02020202, 32'h03030303,
               32'h04040404, 32'h05050505};
        Reset       = 1'b0;
        Run         = 1'b0;
        Output_Data = '0;
        repeat (3) @(negedge Clock);
        chk("rst_tx",   32'(Tx), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_ovf",  32'(Overflow), 32'd0);
        chk("rst_cnt",  32'(Fifo_Count), 32'd0);

        // Single word, latency and Busy fall
        Reset       = 1'b1;
        Run         = 1'b1;
        Output_Data = 32'h000000A5;
        @(negedge Clock);
        chk("t1_cnt_push",  32'(Fifo_Count), 32'd1);
        chk("t1_busy_push", 32'(Busy), 32'd1);
        chk("t1_tx_push",   32'(Tx), 32'd1);
        @(negedge Clock);
        chk("t1_cnt_pop", 32'(Fifo_Count), 32'd0);
        chk("t1_tx_pop",  32'(Tx), 32'd1);
        @(negedge Clock);
        chk("t1_start", 32'(Tx), 32'd0);
        repeat (158) @(negedge Clock);
        chk("t1_busy_last", 32'(Busy), 32'd1);
        @(negedge Clock);
        chk("t1_busy_fall", 32'(Busy), 32'd0);
        wait_rx(1, 20, "t1_rx_count");
        pop_chk("t1_word", 32'h000000A5);
        repeat (200) @(negedge Clock);
        chk("t1_no_repeat", 32'(rx_q.size()), 32'd0);
        chk("t1_tx_idle",   32'(Tx), 32'd1);

        // Run=0 blocks capture
        Run         = 1'b0;
        Output_Data = 32'h1;
        @(negedge Clock);
        chk("t2_cnt_1", 32'(Fifo_Count), 32'd0);
        Output_Data = 32'h2;
        @(negedge Clock);
        chk("t2_cnt_2", 32'(Fifo_Count), 32'd0);
        Output_Data = 32'h3;
        @(negedge Clock);
        chk("t2_cnt_3",  32'(Fifo_Count), 32'd0);
        chk("t2_tx",     32'(Tx), 32'd1);
        chk("t2_busy",   32'(Busy), 32'd0);
        Run = 1'b1;
        wait_rx(1, 300, "t2_rx_count");
        pop_chk("t2_word", 32'h00000003);
        repeat (100) @(negedge Clock);
        chk("t2_single", 32'(rx_q.size()), 32'd0);

        // Six back-to-back values, sixth dropped
        for (int i = 0; i < 6; i++) begin
            Output_Data = v3[i];
            @(negedge Clock);
        end
        chk("t3_ovf", 32'(Overflow), 32'd1);
        chk("t3_cnt", 32'(Fifo_Count), 32'd4);
        wait_rx(5, 1200, "t3_rx_count");
        gap = (rx_t.size() >= 2) ? rx_t[1] - rx_t[0] : -1;
        chk("t3_gap", 32'(gap), 32'd161);
        for (int i = 0; i < 5; i++) pop_chk("t3_word", v3[i]);
        repeat (100) @(negedge Clock);
        chk("t3_no_sixth", 32'(rx_q.size()), 32'd0);
        chk("t3_ovf_sticky", 32'(Overflow), 32'd1);

        // Push on the pop edge of a full FIFO
        Reset = 1'b0;
        #1;
        chk("t4_rst_ovf", 32'(Overflow), 32'd0);
        chk("t4_rst_tx",  32'(Tx), 32'd1);
        @(negedge Clock);
        Reset       = 1'b1;
        Output_Data = '0;
        @(negedge Clock);
        for (int i = 0; i < 5; i++) begin
            Output_Data = v4[i];
            @(negedge Clock);
        end
        repeat (156) @(negedge Clock);
        chk("t4_full",     32'(Fifo_Count), 32'd4);
        chk("t4_ovf_pre",  32'(Overflow), 32'd0);
        @(negedge Clock);
        chk("t4_full_idle", 32'(Fifo_Count), 32'd4);
        Output_Data = 32'h07070707;
        @(negedge Clock);
        chk("t4_cnt_same", 32'(Fifo_Count), 32'd4);
        chk("t4_ovf_same", 32'(Overflow), 32'd0);
        wait_rx(6, 1300, "t4_rx_count");
        for (int i = 0; i < 5; i++) pop_chk("t4_word", v4[i]);
        pop_chk("t4_word_last", 32'h07070707);

        // Reset in the middle of byte 2
        repeat (20) @(negedge Clock);
        Output_Data = 32'h12345678;
        @(negedge Clock);
        Output_Data = 32'h0BADF00D;
        @(negedge Clock);
        chk("t5_cnt_pre", 32'(Fifo_Count), 32'd1);
        @(negedge Clock);
        chk("t5_start", 32'(Tx), 32'd0);
        repeat (97) @(negedge Clock);
        chk("t5_bit3", 32'(Tx), 32'd0);
        Reset = 1'b0;
        #1;
        chk("t5_tx",   32'(Tx), 32'd1);
        chk("t5_cnt",  32'(Fifo_Count), 32'd0);
        chk("t5_busy", 32'(Busy), 32'd0);
        chk("t5_ovf",  32'(Overflow), 32'd0);
        repeat (3) @(negedge Clock);
        Run   = 1'b0;
        Reset = 1'b1;
        repeat (300) @(negedge Clock);
        chk("t5_no_remnant", 32'(rx_q.size()), 32'd0);
        chk("t5_tx_idle",    32'(Tx), 32'd1);
        chk("t5_busy_idle",  32'(Busy), 32'd0);

        // Value, zero, same value again
        Run         = 1'b1;
        Output_Data = 32'hDEADBEEF;
        @(negedge Clock);
        Output_Data = 32'h0;
        @(negedge Clock);
        Output_Data = 32'hDEADBEEF;
        @(negedge Clock);
        wait_rx(3, 700, "t6_rx_count");
        pop_chk("t6_word0", 32'hDEADBEEF);
        pop_chk("t6_word1", 32'h00000000);
        pop_chk("t6_word2", 32'hDEADBEEF);

        chk("frame_err", 32'(frame_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/outport_uart_tx.md
Name: outport_uart_tx

Overview:
- External-side consumer of the Mini SRC CPU output port.
- Watches the CPU's 32-bit Output_Data bus and captures each new value while the CPU is running.
- Buffers captured words in a small FIFO and serialises each word as four 8N1 UART frames, least-significant byte first, on a single Tx line.
- Sits at the CPU top level beside RAM, so board-level logic or a host terminal can observe program output without a strobe from the CPU.

Parameters:
- CLKS_PER_BIT, 434, Clock cycles per UART bit. Minimum 2.
- FIFO_DEPTH, 4, Word entries in the capture FIFO. Power of two, 2 to 16.
- CNT_W, 3, Width of Fifo_Count. Must equal log2(FIFO_DEPTH)+1.

Ports:
- Clock  input  1  System clock; all state updates on the rising edge.
- Reset  input  1  Asynchronous, active-low reset (asserted when 0).
- Output_Data  input  32  CPU output-port value.
- Run  input  1  CPU run flag; capture is enabled only while Run=1.
- Tx  output  1  UART serial output; idles high.
- Busy  output  1  High while a frame is in progress or the FIFO is non-empty.
- Overflow  output  1  Sticky flag: a word was dropped because the FIFO was full.
- Fifo_Count  output  CNT_W  Number of words currently held in the FIFO.

Behaviour:
Reset values:
- Tx=1, Busy=0, Overflow=0, Fifo_Count=0.
- Last_Data=0 (internal), FSM=IDLE, FIFO pointers=0.
- Reset takes effect immediately, including mid-frame: Tx returns to 1 asynchronously and any partial word is discarded.

Capture (change detect):
- A push request occurs on a rising edge when Run=1 and Output_Data != Last_Data.
- On every push request, Last_Data <= Output_Data, whether or not the word is accepted.
- The word is accepted if Fifo_Count < FIFO_DEPTH, or if a pop occurs in the same cycle.
- Otherwise the word is dropped and Overflow <= 1. Overflow clears only on reset.
- When Run=0, nothing is captured and Last_Data holds its value.
- Output_Data equal to Last_Data is never captured. A first value of 0 after reset is therefore not sent.

FIFO:
- Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
- Fifo_Count changes by +1, -1, or 0 when a push and a pop occur together.

Transmit FSM states: IDLE, START, DATA, STOP.
- IDLE: when Fifo_Count != 0, pop the head word into Shift_Word, set Byte_Idx=0, go to START. Tx=1 while in IDLE.
- START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with Bit_Idx=0.
- DATA: Tx = Shift_Word[8*Byte_Idx + Bit_Idx], each bit held CLKS_PER_BIT cycles. Advance after bit 7.
- STOP: Tx=1 for CLKS_PER_BIT cycles. Then:
  - if Byte_Idx=3, go to IDLE;
  - otherwise Byte_Idx+1 and go to START.

Timing:
- One word occupies exactly 40*CLKS_PER_BIT cycles of Tx activity, with no idle gap between its four bytes.
- Back-to-back words are separated by exactly one IDLE cycle.
- Latency: a capture edge at cycle n writes the FIFO at n. If the FSM is IDLE, the pop happens at n+1 and the start bit begins at n+2.
- Busy = (FSM != IDLE) or (Fifo_Count != 0). It is registered together with the state.

Test Plan:
Use CLKS_PER_BIT=4 and FIFO_DEPTH=4 for all scenarios.
1. Release reset, Run=1, Output_Data=0x000000A5 for 200 cycles:
   - Tx frames 0xA5, 0x00, 0x00, 0x00, in that order.
   - Each frame: start bit low, LSB first, stop bit high.
   - Exactly 160 active cycles; Busy falls afterwards.
   - Output held constant produces no repeat transmission.
2. Hold Run=0 and toggle Output_Data through 0x1, 0x2, 0x3:
   - Fifo_Count stays 0 and Tx stays 1.
   - Then set Run=1 with Output_Data=0x3: exactly one word, 0x00000003, is sent.
3. With Run=1, write 6 distinct values on consecutive cycles, starting while IDLE:
   - First word is popped; 4 words fill the FIFO; 6th word dropped, Overflow=1, Fifo_Count=4.
   - Five words are transmitted in order.
4. FIFO full and the FSM returning to IDLE, then present a new value on the pop cycle:
   - The word is accepted, Fifo_Count stays 4, and Overflow is unchanged.
5. Assert Reset low during bit 3 of byte 2 of 0x12345678:
   - Tx=1 in the same cycle; Fifo_Count=0; Busy=0; Overflow=0.
   - After release, no remnant bits appear on Tx.
6. Write 0xDEADBEEF, then 0x0, then 0xDEADBEEF:
   - Three words are captured and sent: bytes EF BE AD DE, then 00 00 00 00, then EF BE AD DE.
